// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: snoops CPU writes, queues bytes in a FIFO and sends 8N1 frames.
// Optional even parity bit (8E1) when UART_PARITY_EN is defined.
module uart_tx_port #(
    parameter int                   WORD_SIZE    = 20,
    parameter int                   CLKS_PER_BIT = 16,
    parameter int                   FIFO_DEPTH   = 8,
    parameter logic [WORD_SIZE-1:0] TX_ADDR      = 'h3fff,
    parameter logic [WORD_SIZE-1:0] STATUS_ADDR  = 'h3ffe
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] addr_i,
    input  logic [WORD_SIZE-1:0] value_i,
    input  logic                 write_i,
    output logic [WORD_SIZE-1:0] status_o,
    output logic                 tx_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               tx_q, tx_d;
    logic [WORD_SIZE-1:0] status_q, status_d;
`ifdef UART_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic push_req, clr_req, fifo_full, fifo_empty, push_ok, pop, tx_busy;
    logic unused_value_bits;

    assign unused_value_bits = ^value_i[WORD_SIZE-1:8];

    always_comb begin
        push_req   = write_i && (addr_i == TX_ADDR);
        clr_req    = write_i && (addr_i == STATUS_ADDR);
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        push_ok    = push_req && !fifo_full;
        pop        = (state_q == ST_IDLE) && !fifo_empty;
        tx_busy    = (state_q != ST_IDLE);

        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);

        // A dropped push and a clear in the same cycle: the drop wins.
        if (push_req && fifo_full) begin
            overflow_d = 1'b1;
        end else if (clr_req) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        status_d = WORD_SIZE'({overflow_q, tx_busy, fifo_empty, fifo_full});
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
`ifdef UART_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    shift_d    = mem_q[rd_ptr_q];
`ifdef UART_PARITY_EN
                    parity_d   = ^mem_q[rd_ptr_q];
`endif
                    bit_idx_d  = '0;
                    baud_cnt_d = BAUD_MAX;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (baud_cnt_q == '0) begin
                    baud_cnt_d = BAUD_MAX;
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_cnt_q == '0) begin
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 1'b1;
                    baud_cnt_d = BAUD_MAX;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (baud_cnt_q == '0) begin
                    baud_cnt_d = BAUD_MAX;
                    state_d    = ST_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level follows the next state so tx_o comes straight from a flop.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
            status_q   <= WORD_SIZE'(2);
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
            status_q   <= status_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_PARITY_EN
        parity_q <= parity_d;
`endif
        if (push_ok) begin
            mem_q[wr_ptr_q] <= value_i[7:0];
        end
    end

    assign tx_o     = tx_q;
    assign status_o = status_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port (CLKS_PER_BIT=4, FIFO_DEPTH=8); frames decoded from tx_o.
module tb_uart_tx_port;

    localparam int WS  = 20;
    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int FL = 11 * CPB;
`else
    localparam int FL = 10 * CPB;
`endif
    localparam logic [WS-1:0] TXA = 'h3fff;
    localparam logic [WS-1:0] STA = 'h3ffe;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [WS-1:0] addr_i = '0;
    logic [WS-1:0] value_i = '0;
    logic          write_i = 1'b0;
    logic [WS-1:0] status_o;
    logic          tx_o;

    uart_tx_port #(
        .WORD_SIZE(WS), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8),
        .TX_ADDR(TXA), .STATUS_ADDR(STA)
    ) dut (
        .clk(clk), .reset(reset), .addr_i(addr_i), .value_i(value_i),
        .write_i(write_i), .status_o(status_o), .tx_o(tx_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [FL-1:0] exp_line(input logic [7:0] d);
        logic [FL-1:0] l;
        for (int j = 0; j < FL; j++) begin
            if (j < CPB)            l[j] = 1'b0;
            else if (j < 9 * CPB)   l[j] = d[(j - CPB) / CPB];
`ifdef UART_PARITY_EN
            else if (j < 10 * CPB)  l[j] = ^d;
`endif
            else                    l[j] = 1'b1;
        end
        return l;
    endfunction

    // Monitor: decode every frame on tx_o and compare against the scoreboard.
    initial begin : monitor
        logic [FL-1:0] line;
        int            fstart;
        bit            aborted;
        exp_t          e;
        while (!mon_en) @(negedge clk);
        forever begin
            @(negedge clk);
            if (!reset && tx_o === 1'b0) begin
                fstart  = cyc;
                line    = '0;
                aborted = 1'b0;
                for (int j = 1; j < FL; j++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    line[j] = tx_o;
                end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", {32'd0, fstart}, 64'hffff_ffff);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("frame_bits_%02h", e.data), 64'(line), 64'(exp_line(e.data)));
                        if (e.start >= 0)
                            chk($sformatf("frame_start_%02h", e.data), 64'(fstart), 64'(e.start));
                    end
                end
            end
        end
    end

    task automatic drive(input logic [WS-1:0] a, input logic [7:0] v, input logic w, output int n);
        @(posedge clk);
        #1;
        addr_i  = a;
        value_i = {12'h000, v};
        write_i = w;
        n = cyc;
    endtask

    task automatic go_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample_at(input int t);
        go_cycle(t);
        @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, n0, d;
        // 1: reset and idle
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        sample_at(cyc + 1);
        chk("reset_tx", 64'(tx_o), 64'd1);
        chk("reset_status", 64'(status_o), 64'h2);
        sample_at(cyc + 10);
        chk("idle_tx", 64'(tx_o), 64'd1);
        chk("idle_status", 64'(status_o), 64'h2);

        // 2: single byte, latency and busy timing
        drive(TXA, 8'h41, 1'b1, n);
        exp_q.push_back('{data: 8'h41, start: n + 2});
        drive('0, 8'h00, 1'b0, d);
        sample_at(n + 3);
        chk("busy_status", 64'(status_o), 64'h6);
        sample_at(n + 2 + FL);
        chk("busy_last_stop", 64'(status_o), 64'h6);
        sample_at(n + 3 + FL);
        chk("busy_dropped", 64'(status_o), 64'h2);
        drain("drain_single", 200);

        // 3: ten back-to-back writes, last one overflows
        for (int i = 0; i < 10; i++) begin
            drive(TXA, 8'h30 + 8'(i), 1'b1, n);
            if (i == 0) n0 = n;
            if (i < 9) exp_q.push_back('{data: 8'h30 + 8'(i), start: n0 + 2 + i * (FL + 1)});
        end
        drive('0, 8'h00, 1'b0, d);
        sample_at(n0 + 11);
        chk("overflow_full_status", 64'(status_o), 64'hD);
        drain("drain_burst", 10 * (FL + 1) + 50);

        // 4: clear overflow, then a write elsewhere
        drive(STA, 8'h00, 1'b1, n);
        drive('0, 8'h00, 1'b0, d);
        sample_at(n + 1);
        chk("overflow_before_clear", 64'(status_o), 64'hA);
        sample_at(n + 2);
        chk("overflow_cleared", 64'(status_o), 64'h2);
        drive(WS'('h0100), 8'h55, 1'b1, n);
        drive('0, 8'h00, 1'b0, d);
        sample_at(n + 3);
        chk("other_addr_status", 64'(status_o), 64'h2);
        chk("other_addr_tx", 64'(tx_o), 64'd1);
        sample_at(n + 20);
        chk("other_addr_quiet", 64'(tx_o), 64'd1);

        // 5: reset during data bit 3 with three bytes queued
        for (int i = 0; i < 4; i++) begin
            drive(TXA, 8'h50 + 8'(i), 1'b1, n);
            if (i == 0) n0 = n;
        end
        drive('0, 8'h00, 1'b0, d);
        go_cycle(n0 + 19);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_tx", 64'(tx_o), 64'd1);
        chk("abort_status", 64'(status_o), 64'h2);
        sample_at(n0 + 20 + 4 * FL);
        chk("abort_quiet_tx", 64'(tx_o), 64'd1);
        chk("abort_quiet_status", 64'(status_o), 64'h2);

        // 6: two frames back to back (parity bits 0 and 1 when enabled)
        drive(TXA, 8'h41, 1'b1, n);
        drive(TXA, 8'h07, 1'b1, d);
        drive('0, 8'h00, 1'b0, d);
        exp_q.push_back('{data: 8'h41, start: n + 2});
        exp_q.push_back('{data: 8'h07, start: n + 2 + FL + 1});
        drain("drain_pair", 3 * FL + 50);
        sample_at(cyc + 5);
        chk("final_status", 64'(status_o), 64'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
